// File: rtl/arith_unit_seq.sv
// arith_unit_seq
// Sequential arithmetic unit: add, subtract and multiply finish one cycle
// after the accept edge; divide runs as a restoring divider over DATA_WIDTH
// cycles while busy_alu is high. All outputs are registered and hold until
// the next completed operation.
//
// Ports
//   clk               system clock, rising edge
//   rst               asynchronous active-high reset
//   A, B              unsigned operands, DATA_WIDTH bits
//   alu_fuc_arith     op select: 00 add, 01 sub, 10 mul, 11 div
//   arith_enable_alu  request strobe, sampled only while busy_alu = 0
//   arith_out_alu     result, OUT_WIDTH bits
//   arith_flag_alu    one-cycle result-valid pulse per accepted op
//   carry_out_alu     add carry / sub borrow, 0 for mul and div
//   div_zero_alu      division by zero status
//   busy_alu          high while a division is iterating
module arith_unit_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [1:0]            alu_fuc_arith,
    input  logic                  arith_enable_alu,
    output logic [OUT_WIDTH-1:0]  arith_out_alu,
    output logic                  arith_flag_alu,
    output logic                  carry_out_alu,
    output logic                  div_zero_alu,
    output logic                  busy_alu
);

    localparam int DW    = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic {
        IDLE,
        DIV
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Divider datapath registers (no reset: only meaningful while in DIV)
    logic [DW-1:0] divisor;
    logic [DW-1:0] quo;
    logic [DW-1:0] rem;

    logic          accept;
    logic          start_div;

    logic [DW:0]   rem_shift;
    logic [DW:0]   trial;
    logic [DW-1:0] rem_next;
    logic [DW-1:0] quo_next;

    logic [DW:0]          sum;
    logic [DW:0]          diff;
    logic [2*DW-1:0]      prod;
    logic [OUT_WIDTH-1:0] op_result;
    logic                 op_carry;
    logic                 op_dz;
    logic [OUT_WIDTH-1:0] div_result;

    assign accept    = arith_enable_alu && !busy_alu;
    assign start_div = accept && (alu_fuc_arith == OP_DIV) && (B != '0);

    // One restoring-division step. rem < divisor always holds between steps,
    // so the shifted remainder fits in DW+1 bits and bit DW of the trial
    // difference is a reliable "went negative" indicator.
    always_comb begin
        rem_shift = {rem, quo[DW-1]};
        trial     = rem_shift - {1'b0, divisor};
        if (trial[DW]) begin
            rem_next = rem_shift[DW-1:0];
            quo_next = {quo[DW-2:0], 1'b0};
        end else begin
            rem_next = trial[DW-1:0];
            quo_next = {quo[DW-2:0], 1'b1};
        end
    end

    // Quotient in the low half, remainder above it, zero fill on top
    always_comb begin
        div_result                = '0;
        div_result[DW-1:0]        = quo_next;
        div_result[2*DW-1:DW]     = rem_next;
    end

    // Single-cycle results; divide-by-zero is also resolved here
    always_comb begin
        sum       = {1'b0, A} + {1'b0, B};
        diff      = {1'b0, A} - {1'b0, B};
        prod      = {{DW{1'b0}}, A} * {{DW{1'b0}}, B};
        op_result = '0;
        op_carry  = 1'b0;
        op_dz     = 1'b0;
        case (alu_fuc_arith)
            OP_ADD: begin
                op_result[DW:0] = sum;
                op_carry        = sum[DW];
            end
            OP_SUB: begin
                // (DW+1)-bit two's complement difference, sign-extended
                op_result       = {OUT_WIDTH{diff[DW]}};
                op_result[DW:0] = diff;
                op_carry        = diff[DW];
            end
            OP_MUL: begin
                op_result[2*DW-1:0] = prod;
            end
            OP_DIV: begin
                // Only reached with B = 0; non-zero B goes through DIV
                op_result[DW-1:0]    = '1;
                op_result[2*DW-1:DW] = A;
                op_dz                = 1'b1;
            end
            default: begin
                op_result = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (start_div) begin
            divisor <= B;
            quo     <= A;
            rem     <= '0;
        end else if (state == DIV) begin
            rem <= rem_next;
            quo <= quo_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            arith_out_alu  <= '0;
            arith_flag_alu <= 1'b0;
            carry_out_alu  <= 1'b0;
            div_zero_alu   <= 1'b0;
            busy_alu       <= 1'b0;
        end else begin
            arith_flag_alu <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_div) begin
                        state    <= DIV;
                        busy_alu <= 1'b1;
                        cnt      <= CNT_W'(DATA_WIDTH);
                    end else if (accept) begin
                        arith_out_alu  <= op_result;
                        carry_out_alu  <= op_carry;
                        div_zero_alu   <= op_dz;
                        arith_flag_alu <= 1'b1;
                    end
                end
                DIV: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state          <= IDLE;
                        busy_alu       <= 1'b0;
                        arith_out_alu  <= div_result;
                        carry_out_alu  <= 1'b0;
                        div_zero_alu   <= 1'b0;
                        arith_flag_alu <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy_alu <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/arith_unit_seq.md
Name: arith_unit_seq

Overview:
- Parametrised successor to the single-cycle arithmetic unit inside the ALU. Performs add, subtract, multiply and divide on DATA_WIDTH operands.
- Add, sub and mul complete in one cycle. Divide runs as an iterative restoring divider over DATA_WIDTH cycles, with a busy/valid handshake.
- Adds carry/borrow and divide-by-zero status. Results hold until the next accepted operation.

Parameters:
- DATA_WIDTH, 8, operand width (legal range 2..32).
- OUT_WIDTH, 2*DATA_WIDTH, result width. Must be ≥ 2*DATA_WIDTH; extra upper bits are zero or sign fill.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- A  input  DATA_WIDTH  operand A (unsigned).
- B  input  DATA_WIDTH  operand B (unsigned).
- alu_fuc_arith  input  2  op select: 00 add, 01 sub, 10 mul, 11 div.
- arith_enable_alu  input  1  request strobe; sampled only when busy_alu=0.
- arith_out_alu  output  OUT_WIDTH  registered result.
- arith_flag_alu  output  1  result-valid pulse, high exactly one cycle per accepted op.
- carry_out_alu  output  1  add carry / sub borrow; 0 for mul and div.
- div_zero_alu  output  1  set on division with B=0.
- busy_alu  output  1  high while a division is iterating.

Behaviour:
Reset:
- rst=1 forces all outputs to 0, FSM to IDLE and the iteration counter to 0, immediately (asynchronous).
- Reset mid-division aborts it. No valid pulse is issued for the aborted op.

Accept:
- An op is accepted at a rising edge where arith_enable_alu=1 and busy_alu=0.
- Enable while busy is ignored: operands are not captured and no queueing occurs.

Single-cycle ops (state IDLE):
- Add: out = zero-extend(A+B). carry = bit DATA_WIDTH of the sum, which is also present in out.
- Sub: out = sign-extend the (DATA_WIDTH+1)-bit two's-complement A−B to OUT_WIDTH. carry = borrow = (A<B).
- Mul: out = full unsigned product A*B, zero-extended. carry = 0.
- For all three, the result, flags and valid appear the cycle after the accept edge. div_zero is cleared.

Divide, non-zero B:
- Accept edge: latch dividend=A and divisor=B, clear the partial remainder, set counter=DATA_WIDTH, enter DIV, set busy_alu=1. arith_out_alu holds its previous value.
- DIV, each edge: shift {rem,quo} left by 1, trial-subtract the divisor from rem, restore if negative, set the quotient bit, decrement counter.
- On the DATA_WIDTH-th DIV edge: load the result, pulse valid, clear busy and carry, return to IDLE.
- Result layout: out[DATA_WIDTH-1:0] = quotient, out[2*DATA_WIDTH-1:DATA_WIDTH] = remainder, higher bits 0.
- Total latency from accept edge to valid: DATA_WIDTH cycles. Back-to-back accept is possible on the cycle valid is high, since busy is already 0.

Divide, B=0:
- No iteration, one-cycle latency.
- Quotient = all ones, remainder = A, div_zero=1, carry=0, busy stays 0.

Hold and flag clearing:
- arith_out_alu, carry and div_zero hold until the next completed op.
- carry and div_zero are updated together with the result, never independently.
- arith_flag_alu returns to 0 the cycle after its pulse.

Undefined or X on alu_fuc_arith is not supported. The case default produces result 0 with a valid pulse.

Test Plan:
1. Reset then add: A=8'hF0, B=8'h20 → next cycle out=16'h0110, carry=1, flag pulse 1 cycle.
2. Sub: A=3, B=5 → out=16'hFFFE, carry=1; A=9, B=4 → out=16'h0005, carry=0.
3. Mul: A=8'hFF, B=8'hFF → out=16'hFE01, carry=0, 1-cycle latency.
4. Div and busy: A=100, B=7 → busy high 8 cycles, flag on cycle 8 after accept, out=16'h020E (rem 2, quo 14). An enable pulse with A=1, B=1 issued mid-division is ignored.
5. Div by zero: A=8'h2A, B=0 → next cycle out=16'h2AFF, div_zero=1, busy never asserted. A following add clears div_zero.
6. Reset mid-division: assert rst at iteration 4 → all outputs 0 immediately, no flag. After release, a fresh div of A=255, B=16 yields 16'h0F0F after 8 cycles.
